// File: rtl/popcnt_seq_acc_if.sv
// Handshake bundle for popcnt_seq_acc: word input stream and packet-total output stream.
interface popcnt_seq_acc_if #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned ACC_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_sat;

    // Source of words / sink of totals.
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count,
        input  out_sat
    );

    // The counting block.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count,
        output out_sat
    );

endinterface

// File: rtl/popcnt_seq_acc.sv
// Sequential population counter: takes WIDTH-bit words over valid/ready, counts CHUNK bits
// per cycle, accumulates a saturating total across a packet ended by in_last and hands the
// total downstream over valid/ready.
module popcnt_seq_acc #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CHUNK = 16,
    parameter int unsigned ACC_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    popcnt_seq_acc_if.slave bus
);

    localparam int unsigned NCH    = WIDTH / CHUNK;
    localparam int unsigned CIDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PC_W   = $clog2(CHUNK + 1);
    localparam int unsigned SUM_W  = ACC_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Captured word, viewed as NCH chunks so the active chunk is a plain array select.
    logic [NCH-1:0][CHUNK-1:0] word_q, word_d;
    logic                      last_q, last_d;
    logic [CIDX_W-1:0]         idx_q, idx_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic                      sat_q, sat_d;

    logic [CHUNK-1:0] chunk;
    logic [PC_W-1:0]  chunk_pc;
    logic [SUM_W-1:0] sum;
    logic             last_chunk;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                if (last_chunk) begin
                    state_d = last_q ? StDone : StIdle;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on state and held registers only, never on the inputs.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.out_count = acc_q;
        bus.out_sat   = sat_q;
    end

    // Popcount of the active chunk and its saturating sum with the accumulator.
    always_comb begin
        chunk      = word_q[idx_q];
        last_chunk = (idx_q == CIDX_W'(NCH - 1));
        chunk_pc   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pc = chunk_pc + PC_W'(chunk[i]);
        end
        sum = {1'b0, acc_q} + SUM_W'(chunk_pc);
    end

    // Datapath next-state: capture in IDLE, accumulate in COUNT, clear on delivery.
    always_comb begin
        word_d = word_q;
        last_d = last_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
        sat_d  = sat_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    word_d = bus.in_data;
                    last_d = bus.in_last;
                    idx_d  = '0;
                end
            end
            StCount: begin
                // Carry out of the ACC_W-bit range means the total no longer fits.
                if (sum[ACC_W]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
                idx_d = last_chunk ? '0 : idx_q + 1'b1;
            end
            StDone: begin
                if (bus.out_ready) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any partial or pending packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            last_q <= 1'b0;
            idx_q  <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            last_q <= last_d;
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            sat_q  <= sat_d;
        end
    end

endmodule
